// File: rtl/ipsxe_floating_point_pkg.sv
// Shared constants and special-value encodings for the floating-point IP family.
package ipsxe_floating_point_pkg;

  localparam int unsigned FP_MAX_W = 128;
  localparam int unsigned FP_IDX_W = $clog2(FP_MAX_W);

  // Exponent bias for an exp_bit-wide exponent field.
  function automatic int unsigned fp_bias(input int unsigned exp_bit);
    return (32'd1 << (exp_bit - 1)) - 32'd1;
  endfunction

  // All-ones biased exponent, reserved for infinity.
  function automatic int unsigned fp_exp_max(input int unsigned exp_bit);
    return (32'd1 << exp_bit) - 32'd1;
  endfunction

  // +0 encoding (all zeros).
  function automatic logic [FP_MAX_W-1:0] fp_pos_zero();
    return '0;
  endfunction

  // Signed zero: only the sign bit may be set.
  function automatic logic [FP_MAX_W-1:0] fp_signed_zero(input logic sign,
                                                         input int unsigned exp_bit,
                                                         input int unsigned frac_bit);
    logic [FP_MAX_W-1:0] r;
    r = '0;
    r[FP_IDX_W'(exp_bit + frac_bit - 1)] = sign;
    return r;
  endfunction

  // Signed infinity: all-ones exponent, zero fraction.
  function automatic logic [FP_MAX_W-1:0] fp_inf(input logic sign,
                                                 input int unsigned exp_bit,
                                                 input int unsigned frac_bit);
    logic [FP_MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < exp_bit; i++) begin
      r[FP_IDX_W'(frac_bit - 1 + i)] = 1'b1;
    end
    r[FP_IDX_W'(exp_bit + frac_bit - 1)] = sign;
    return r;
  endfunction

endpackage

// File: rtl/ipsxe_floating_point_lzc_v1_0.sv
// Combinational leading-zero counter; all-zero input returns W.
module ipsxe_floating_point_lzc_v1_0 #(
  parameter  int unsigned W  = 32,
  localparam int unsigned CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  i_data,
  output logic [CW-1:0] o_count
);

  logic [W-1:0] scan;
  logic         found;

  // Walk from the MSB, counting zeros until the first one.
  always_comb begin
    o_count = '0;
    found   = 1'b0;
    scan    = i_data;
    for (int unsigned i = 0; i < W; i++) begin
      if (!found) begin
        if (scan[W-1]) begin
          found = 1'b1;
        end else begin
          o_count = o_count + CW'(1);
        end
      end
      scan = scan << 1;
    end
  end

endmodule

// File: rtl/ipsxe_floating_point_register_v1_0.sv
// Clock-enabled shift register with async active-low clear; DEPTH stages of WIDTH bits.
module ipsxe_floating_point_register_v1_0 #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             i_aclk,
  input  logic             i_areset_n,
  input  logic             i_aclken,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  localparam int unsigned TOT_W = WIDTH * DEPTH;

  logic [TOT_W-1:0] stage_d;
  logic [TOT_W-1:0] stage_q;

  // Shift a new word in at the bottom when enabled, otherwise hold.
  always_comb begin
    stage_d = stage_q;
    if (i_aclken) begin
      stage_d = (stage_q << WIDTH) | TOT_W'(i_d);
    end
  end

  // Stage storage.
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign o_q = stage_q[TOT_W-1 -: WIDTH];

endmodule

// File: rtl/ipsxe_floating_point_fx2fl_nothalf_v1_0.sv
// Signed fixed-point to floating-point converter, 1..3 register stages, RNE rounding.
// Optional o_inexact output enabled by defining IPSXE_FLOATING_POINT_FX2FL_INEXACT_EN.
module ipsxe_floating_point_fx2fl_nothalf_v1_0
  import ipsxe_floating_point_pkg::*;
#(
  parameter int unsigned FLOAT_EXP_BIT  = 8,
  parameter int unsigned FLOAT_FRAC_BIT = 24,
  parameter int unsigned FIXED_INT_BIT  = 32,
  parameter int unsigned FIXED_FRAC_BIT = 0,
  parameter int unsigned LATENCY_CONFIG = 3
) (
  input  logic                                    i_aclk,
  input  logic                                    i_areset_n,
  input  logic                                    i_aclken,
  input  logic [FIXED_INT_BIT+FIXED_FRAC_BIT-1:0] i_axi4s_a_tdata,
  input  logic                                    i_axi4s_or_abcoperation_tvalid,
  output logic [FLOAT_EXP_BIT+FLOAT_FRAC_BIT-1:0] o_axi4s_result_tdata,
  output logic                                    o_axi4s_result_tvalid,
  output logic                                    o_overflow
`ifdef IPSXE_FLOATING_POINT_FX2FL_INEXACT_EN
  ,
  output logic                                    o_inexact
`endif
);

  localparam int unsigned W       = FIXED_INT_BIT + FIXED_FRAC_BIT;
  localparam int unsigned EW      = FLOAT_EXP_BIT;
  localparam int unsigned FW      = FLOAT_FRAC_BIT;
  localparam int unsigned RW      = EW + FW;
  localparam int unsigned SW      = EW + 2;
  localparam int unsigned CW      = $clog2(W + 1);
  localparam int unsigned BIAS    = fp_bias(EW);
  localparam int unsigned EXP_MAX = fp_exp_max(EW);
  localparam int unsigned B_W     = 1 + W;
  localparam int unsigned C_W     = 1 + W + SW;
`ifdef IPSXE_FLOATING_POINT_FX2FL_INEXACT_EN
  localparam int unsigned D_W     = RW + 2;
`else
  localparam int unsigned D_W     = RW + 1;
`endif

  localparam logic signed [SW-1:0] EXP_MAX_S = SW'(EXP_MAX);
  localparam logic signed [SW-1:0] ZERO_S    = '0;

  // ---------------- Step A: absolute value ----------------
  logic         a_sign_c;
  logic [W-1:0] a_mag_c;

  // Two's-complement magnitude; the most negative input maps to 2^(W-1).
  always_comb begin
    a_sign_c = i_axi4s_a_tdata[W-1];
    a_mag_c  = a_sign_c ? (~i_axi4s_a_tdata + W'(1)) : i_axi4s_a_tdata;
  end

  logic [B_W-1:0] b_pack;

  if (LATENCY_CONFIG >= 3) begin : g_reg_a
    ipsxe_floating_point_register_v1_0 #(.WIDTH(B_W), .DEPTH(1)) u_reg_a (
      .i_aclk     (i_aclk),
      .i_areset_n (i_areset_n),
      .i_aclken   (i_aclken),
      .i_d        ({a_sign_c, a_mag_c}),
      .o_q        (b_pack)
    );
  end else begin : g_byp_a
    assign b_pack = {a_sign_c, a_mag_c};
  end

  // ---------------- Step B: normalise ----------------
  logic                 b_sign;
  logic [W-1:0]         b_mag;
  logic [CW-1:0]        b_lz_c;
  logic [W-1:0]         b_norm_c;
  logic signed [SW-1:0] b_exp_c;

  assign {b_sign, b_mag} = b_pack;

  ipsxe_floating_point_lzc_v1_0 #(.W(W)) u_lzc (
    .i_data  (b_mag),
    .o_count (b_lz_c)
  );

  // Left-justify the magnitude and derive its biased exponent.
  always_comb begin
    b_norm_c = b_mag << b_lz_c;
    b_exp_c  = SW'(BIAS + FIXED_INT_BIT - 1) - SW'(b_lz_c);
  end

  logic [C_W-1:0] c_pack;

  if (LATENCY_CONFIG >= 2) begin : g_reg_b
    ipsxe_floating_point_register_v1_0 #(.WIDTH(C_W), .DEPTH(1)) u_reg_b (
      .i_aclk     (i_aclk),
      .i_areset_n (i_areset_n),
      .i_aclken   (i_aclken),
      .i_d        ({b_sign, b_norm_c, b_exp_c}),
      .o_q        (c_pack)
    );
  end else begin : g_byp_b
    assign c_pack = {b_sign, b_norm_c, b_exp_c};
  end

  // ---------------- Step C: round and classify ----------------
  logic                 c_sign;
  logic [W-1:0]         c_norm;
  logic signed [SW-1:0] c_exp;
  logic [FW-2:0]        c_frac_in;
  logic                 c_guard;
  logic                 c_sticky;
  logic                 c_round_up;
  logic                 c_carry;
  logic [FW-2:0]        c_frac;
  logic signed [SW-1:0] c_exp_r;
  logic [RW-1:0]        c_result;
  logic                 c_ovf;
  logic [D_W-1:0]       d_pack_c;
  logic [D_W-1:0]       d_q;

  assign {c_sign, c_norm, c_exp} = c_pack;

  // Fraction below the hidden one, plus guard/sticky from the bits dropped.
  if (W <= FW) begin : g_exact
    assign c_frac_in = (FW-1)'(c_norm[W-2:0]) << (FW - W);
    assign c_guard   = 1'b0;
    assign c_sticky  = 1'b0;
  end else if (W == FW + 1) begin : g_guard_only
    assign c_frac_in = c_norm[W-2 -: FW-1];
    assign c_guard   = c_norm[0];
    assign c_sticky  = 1'b0;
  end else begin : g_round
    assign c_frac_in = c_norm[W-2 -: FW-1];
    assign c_guard   = c_norm[W-1-FW];
    assign c_sticky  = |c_norm[W-2-FW:0];
  end

  // Round to nearest even, then saturate to infinity or flush to signed zero.
  always_comb begin
    c_round_up          = c_guard & (c_sticky | c_frac_in[0]);
    {c_carry, c_frac}   = FW'(c_frac_in) + FW'(c_round_up);
    c_exp_r             = c_exp + SW'(c_carry);
    c_result            = RW'(fp_pos_zero());
    c_ovf               = 1'b0;
    if (c_norm == '0) begin
      c_result = RW'(fp_pos_zero());
    end else if (c_exp_r >= EXP_MAX_S) begin
      c_result = RW'(fp_inf(c_sign, EW, FW));
      c_ovf    = 1'b1;
    end else if (c_exp_r <= ZERO_S) begin
      c_result = RW'(fp_signed_zero(c_sign, EW, FW));
    end else begin
      c_result = {c_sign, c_exp_r[EW-1:0], c_frac};
    end
`ifdef IPSXE_FLOATING_POINT_FX2FL_INEXACT_EN
    d_pack_c = {c_result, c_ovf, (c_guard | c_sticky | c_ovf)};
`else
    d_pack_c = {c_result, c_ovf};
`endif
  end

  // Output register for result and flags.
  ipsxe_floating_point_register_v1_0 #(.WIDTH(D_W), .DEPTH(1)) u_reg_out (
    .i_aclk     (i_aclk),
    .i_areset_n (i_areset_n),
    .i_aclken   (i_aclken),
    .i_d        (d_pack_c),
    .o_q        (d_q)
  );

  // Valid travels alongside the data through an equally deep shift register.
  ipsxe_floating_point_register_v1_0 #(.WIDTH(1), .DEPTH(LATENCY_CONFIG)) u_reg_vld (
    .i_aclk     (i_aclk),
    .i_areset_n (i_areset_n),
    .i_aclken   (i_aclken),
    .i_d        (i_axi4s_or_abcoperation_tvalid),
    .o_q        (o_axi4s_result_tvalid)
  );

`ifdef IPSXE_FLOATING_POINT_FX2FL_INEXACT_EN
  assign {o_axi4s_result_tdata, o_overflow, o_inexact} = d_q;
`else
  assign {o_axi4s_result_tdata, o_overflow} = d_q;
`endif

endmodule

// File: tb/tb_ipsxe_floating_point_fx2fl_nothalf_v1_0.sv
// Bench: latencies 1/2/3 at default widths plus a narrow-format instance, against an arithmetic model.
module tb_ipsxe_floating_point_fx2fl_nothalf_v1_0;

  localparam int NCH  = 4;
  localparam int NMAX = 512;
  localparam int NSTEP = 300;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        vld;
  logic [31:0] din;
  logic [15:0] din_s;

  always #5 clk = ~clk;

  logic [31:0] res0, res1, res2;
  logic [11:0] res_s;
  logic        v0, v1, v2, v3;
  logic        o0, o1, o2, o3;
  logic        x0, x1, x2, x3;

  logic [31:0] res   [NCH];
  logic        o_vld [NCH];
  logic        o_ovf [NCH];
  logic        o_inx [NCH];
  int          lat   [NCH];
  int          ch_ew [NCH];
  int          ch_fw [NCH];

  always_comb begin
    res[0] = res0; res[1] = res1; res[2] = res2; res[3] = {20'd0, res_s};
    o_vld[0] = v0; o_vld[1] = v1; o_vld[2] = v2; o_vld[3] = v3;
    o_ovf[0] = o0; o_ovf[1] = o1; o_ovf[2] = o2; o_ovf[3] = o3;
    o_inx[0] = x0; o_inx[1] = x1; o_inx[2] = x2; o_inx[3] = x3;
  end

  ipsxe_floating_point_fx2fl_nothalf_v1_0 #(.LATENCY_CONFIG(1)) dut_l1 (
    .i_aclk(clk), .i_areset_n(rst_n), .i_aclken(en), .i_axi4s_a_tdata(din),
    .i_axi4s_or_abcoperation_tvalid(vld), .o_axi4s_result_tdata(res0),
    .o_axi4s_result_tvalid(v0), .o_overflow(o0)
`ifdef IPSXE_FLOATING_POINT_FX2FL_INEXACT_EN
    , .o_inexact(x0)
`endif
  );

  ipsxe_floating_point_fx2fl_nothalf_v1_0 #(.LATENCY_CONFIG(2)) dut_l2 (
    .i_aclk(clk), .i_areset_n(rst_n), .i_aclken(en), .i_axi4s_a_tdata(din),
    .i_axi4s_or_abcoperation_tvalid(vld), .o_axi4s_result_tdata(res1),
    .o_axi4s_result_tvalid(v1), .o_overflow(o1)
`ifdef IPSXE_FLOATING_POINT_FX2FL_INEXACT_EN
    , .o_inexact(x1)
`endif
  );

  ipsxe_floating_point_fx2fl_nothalf_v1_0 dut (
    .i_aclk(clk), .i_areset_n(rst_n), .i_aclken(en), .i_axi4s_a_tdata(din),
    .i_axi4s_or_abcoperation_tvalid(vld), .o_axi4s_result_tdata(res2),
    .o_axi4s_result_tvalid(v2), .o_overflow(o2)
`ifdef IPSXE_FLOATING_POINT_FX2FL_INEXACT_EN
    , .o_inexact(x2)
`endif
  );

  ipsxe_floating_point_fx2fl_nothalf_v1_0 #(
    .FLOAT_EXP_BIT(4), .FLOAT_FRAC_BIT(8), .FIXED_INT_BIT(16)
  ) dut_small (
    .i_aclk(clk), .i_areset_n(rst_n), .i_aclken(en), .i_axi4s_a_tdata(din_s),
    .i_axi4s_or_abcoperation_tvalid(vld), .o_axi4s_result_tdata(res_s),
    .o_axi4s_result_tvalid(v3), .o_overflow(o3)
`ifdef IPSXE_FLOATING_POINT_FX2FL_INEXACT_EN
    , .o_inexact(x3)
`endif
  );

`ifndef IPSXE_FLOATING_POINT_FX2FL_INEXACT_EN
  assign x0 = 1'b0;
  assign x1 = 1'b0;
  assign x2 = 1'b0;
  assign x3 = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference: exact integer -> float by plain arithmetic (floor log2, remainder-based RNE).
  function automatic void ref_conv(input longint v, input int ew, input int fw,
                                   output logic [31:0] r_res, output logic r_ovf,
                                   output logic r_inx);
    longint mag, q, rem, half, r;
    int     e, sh, bexp;
    logic   sgn;
    r_res = '0; r_ovf = 1'b0; r_inx = 1'b0;
    sgn = (v < 0);
    mag = sgn ? -v : v;
    if (mag == 0) return;
    e = 0;
    while ((mag >> (e + 1)) != 0) e++;
    if (e + 1 <= fw) begin
      q = mag << (fw - 1 - e);
    end else begin
      sh   = e + 1 - fw;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = longint'(1) << (sh - 1);
      r_inx = (rem != 0);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (longint'(1) << fw)) begin q = q >> 1; e = e + 1; end
    end
    bexp = (1 << (ew - 1)) - 1 + e;
    r = longint'(sgn) << (ew + fw - 1);
    if (bexp >= (1 << ew) - 1) begin
      r = r | (longint'((1 << ew) - 1) << (fw - 1));
      r_ovf = 1'b1;
      r_inx = 1'b1;
    end else if (bexp > 0) begin
      r = r | (longint'(bexp) << (fw - 1)) | (q - (longint'(1) << (fw - 1)));
    end
    r_res = 32'(r);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; vld = 1'b0; din = '0; din_s = '0;
    repeat (3) @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if ({o_vld[c], res[c], o_ovf[c], o_inx[c]} !== 35'd0) begin
        errors++;
        $display("FAIL reset_state ch%0d got vld=%b data=%h ovf=%b inx=%b want all 0",
                 c, o_vld[c], res[c], o_ovf[c], o_inx[c]);
      end
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] vin [7];
    logic [31:0] vexp [7];
    logic        vinx [7];
    vin  = '{32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h80000000,
             32'h7FFFFFFF, 32'h01000001, 32'h01000003};
    vexp = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'hCF000000,
             32'h4F000000, 32'h4B800000, 32'h4B800002};
    vinx = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 7; k++) begin
      din = vin[k]; vld = 1'b1; en = 1'b1;
      for (int n = 1; n <= 3; n++) begin
        @(negedge clk);
        if (n == 1) begin
          vld = 1'b0;
          checks++;
          if (o_vld[0] !== 1'b1 || res[0] !== vexp[k]) begin
            errors++;
            $display("FAIL directed_l1 in=%h got vld=%b data=%h want vld=1 data=%h",
                     vin[k], o_vld[0], res[0], vexp[k]);
          end
        end
        checks++;
        if (o_vld[2] !== (n == 3)) begin
          errors++;
          $display("FAIL directed_latency in=%h cycle %0d got vld=%b want %b",
                   vin[k], n, o_vld[2], (n == 3));
        end
        if (n == 3) begin
          checks++;
          if (res[2] !== vexp[k] || o_ovf[2] !== 1'b0) begin
            errors++;
            $display("FAIL directed_data in=%h got %h ovf=%b want %h ovf=0",
                     vin[k], res[2], o_ovf[2], vexp[k]);
          end
`ifdef IPSXE_FLOATING_POINT_FX2FL_INEXACT_EN
          checks++;
          if (o_inx[2] !== vinx[k]) begin
            errors++;
            $display("FAIL directed_inexact in=%h got %b want %b", vin[k], o_inx[2], vinx[k]);
          end
`endif
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] vin [3];
    logic [31:0] vexp [3];
    logic        vovf [3];
    vin  = '{16'h0100, 16'hFF00, 16'h00FF};
    vexp = '{32'h780, 32'hF80, 32'h77F};
    vovf = '{1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      din_s = vin[k]; din = '0; vld = 1'b1; en = 1'b1;
      @(negedge clk);
      vld = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (o_vld[3] !== 1'b1 || res[3] !== vexp[k] || o_ovf[3] !== vovf[k]) begin
        errors++;
        $display("FAIL overflow in=%h got vld=%b data=%h ovf=%b want vld=1 data=%h ovf=%b",
                 vin[k], o_vld[3], res[3], o_ovf[3], vexp[k], vovf[k]);
      end
`ifdef IPSXE_FLOATING_POINT_FX2FL_INEXACT_EN
      checks++;
      if (o_inx[3] !== vovf[k]) begin
        errors++;
        $display("FAIL overflow_inexact in=%h got %b want %b", vin[k], o_inx[3], vovf[k]);
      end
`endif
    end
    din_s = '0;
    repeat (3) @(negedge clk);
  endtask

  int          acc   [NMAX];
  logic [31:0] e_res [NCH][NMAX];
  logic        e_ovf [NCH][NMAX];
  logic        e_inx [NCH][NMAX];

  task automatic test_back_to_back();
    int          wr, ecnt, age;
    int          rd [NCH];
    logic [31:0] p_res [NCH];
    logic        p_vld [NCH];
    logic        p_ovf [NCH];
    logic [31:0] r32;
    logic [15:0] r16;
    logic        m_ovf, m_inx;
    logic [31:0] m_res;
    wr = 0; ecnt = 0;
    for (int c = 0; c < NCH; c++) begin
      rd[c] = 0; p_res[c] = res[c]; p_vld[c] = o_vld[c]; p_ovf[c] = o_ovf[c];
    end
    for (int s = 0; s < NSTEP + 6; s++) begin
      if (s >= NSTEP) begin
        en = 1'b1; vld = 1'b0;
      end else begin
        en  = (s == 60 || s == 61) ? 1'b0 : ($urandom_range(0, 7) != 0);
        vld = ($urandom_range(0, 7) != 0);
        case ($urandom_range(0, 4))
          0: r32 = $urandom;
          1: r32 = $urandom_range(0, 255);
          2: r32 = 32'd1 << $urandom_range(0, 31);
          3: r32 = 32'h80000000 ^ 32'($urandom_range(0, 3));
          default: r32 = (($urandom | 32'h01000000) & 32'h01FFFF00) | 32'h80;
        endcase
        if ($urandom_range(0, 1) == 1) r32 = -r32;
        din = r32;
        case ($urandom_range(0, 2))
          0: r16 = 16'($urandom);
          1: r16 = 16'($urandom_range(0, 300));
          default: r16 = 16'd1 << $urandom_range(0, 15);
        endcase
        if ($urandom_range(0, 1) == 1) r16 = -r16;
        din_s = r16;
      end
      @(negedge clk);
      if (en) begin
        ecnt++;
        if (vld) begin
          acc[wr] = ecnt;
          for (int c = 0; c < NCH; c++) begin
            if (c == 3) ref_conv(longint'($signed(din_s)), 4, 8, m_res, m_ovf, m_inx);
            else        ref_conv(longint'($signed(din)), 8, 24, m_res, m_ovf, m_inx);
            e_res[c][wr] = m_res; e_ovf[c][wr] = m_ovf; e_inx[c][wr] = m_inx;
          end
          wr++;
        end
      end
      for (int c = 0; c < NCH; c++) begin
        checks++;
        if (!en) begin
          if (o_vld[c] !== p_vld[c] || res[c] !== p_res[c] || o_ovf[c] !== p_ovf[c]) begin
            errors++;
            $display("FAIL hold ch%0d step %0d got vld=%b data=%h ovf=%b want vld=%b data=%h ovf=%b",
                     c, s, o_vld[c], res[c], o_ovf[c], p_vld[c], p_res[c], p_ovf[c]);
          end
        end else if (o_vld[c] === 1'b1) begin
          if (rd[c] >= wr) begin
            errors++;
            $display("FAIL stream_extra ch%0d step %0d got valid want none pending", c, s);
          end else begin
            age = ecnt - acc[rd[c]];
            if (res[c] !== e_res[c][rd[c]] || o_ovf[c] !== e_ovf[c][rd[c]] ||
                age != lat[c] - 1
`ifdef IPSXE_FLOATING_POINT_FX2FL_INEXACT_EN
                || o_inx[c] !== e_inx[c][rd[c]]
`endif
               ) begin
              errors++;
              $display("FAIL stream ch%0d item %0d got data=%h ovf=%b inx=%b lat=%0d want data=%h ovf=%b inx=%b lat=%0d",
                       c, rd[c], res[c], o_ovf[c], o_inx[c], age + 1,
                       e_res[c][rd[c]], e_ovf[c][rd[c]], e_inx[c][rd[c]], lat[c]);
            end
            rd[c]++;
          end
        end else begin
          if (rd[c] < wr && (ecnt - acc[rd[c]]) >= lat[c] - 1) begin
            errors++;
            $display("FAIL stream_missing ch%0d item %0d got no valid want data=%h",
                     c, rd[c], e_res[c][rd[c]]);
            rd[c]++;
          end
        end
        p_res[c] = res[c]; p_vld[c] = o_vld[c]; p_ovf[c] = o_ovf[c];
      end
    end
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (rd[c] != wr) begin
        errors++;
        $display("FAIL stream_count ch%0d got %0d outputs want %0d", c, rd[c], wr);
      end
    end
  endtask

  task automatic test_reset_midflight();
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      vld = 1'b1; din = $urandom | 32'h1; din_s = 16'h0011;
      @(negedge clk);
    end
    vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if ({o_vld[c], res[c], o_ovf[c], o_inx[c]} !== 35'd0) begin
        errors++;
        $display("FAIL midflight_reset ch%0d got vld=%b data=%h ovf=%b inx=%b want all 0",
                 c, o_vld[c], res[c], o_ovf[c], o_inx[c]);
      end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        checks++;
        if (o_vld[c] !== 1'b0) begin
          errors++;
          $display("FAIL stale_valid ch%0d cycle %0d got vld=%b want 0", c, n, o_vld[c]);
        end
      end
    end
  endtask

  initial begin
    lat   = '{1, 2, 3, 3};
    ch_ew = '{8, 8, 8, 4};
    ch_fw = '{24, 24, 24, 8};
    rst_n = 1'b0; en = 1'b1; vld = 1'b0; din = '0; din_s = '0;
    test_reset();
    test_directed();
    test_overflow();
    test_back_to_back();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
